// File: rtl/cobra_pc_fetch.sv
// rtl/cobra_pc_fetch.sv - cobra program-counter and fetch sequencer (optional taken-branch counter via COBRA_BR_CNT_EN)
module cobra_pc_fetch #(
    parameter int          AW     = 32,
    parameter int          OFFS_W = 13,
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              instr_req,
    output logic [AW-1:0]     instr_addr,
    input  logic              instr_ack,
    input  logic [31:0]       instr_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr_out,
    input  logic              exec_done,
    input  logic              alu_c,
    input  logic              jump,
    input  logic              branch,
    input  logic [OFFS_W-1:0] offs,
    input  logic              halt,
    output logic [AW-1:0]     pc,
    output logic              halted
`ifdef COBRA_BR_CNT_EN
    ,
    output logic [15:0]       br_taken_cnt
`endif
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [AW-1:0] RST_PC_AW = AW'(RST_PC);

    logic [1:0]    state;
    logic [AW-1:0] offs_sext;
    logic          take_target;
    logic [AW-1:0] pc_next;
    logic          done_fire;

    assign offs_sext   = {{(AW-OFFS_W){offs[OFFS_W-1]}}, offs};
    // jump and taken branch share one adder path, so jump+branch needs no arbitration
    assign take_target = jump | (branch & alu_c);
    assign pc_next     = pc + (take_target ? offs_sext : AW'(4));
    assign done_fire   = (state == S_EXEC) && exec_done;

    assign instr_addr  = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            pc          <= RST_PC_AW;
            instr_req   <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= 32'h0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    state     <= S_FETCH;
                    instr_req <= 1'b1;
                end
                S_FETCH: begin
                    if (instr_ack) begin
                        instr_out   <= instr_rdata;
                        instr_valid <= 1'b1;
                        instr_req   <= 1'b0;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            pc        <= pc_next;
                            instr_req <= 1'b1;
                            state     <= S_FETCH;
                        end
                    end
                end
                default: begin
                    instr_req   <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
            endcase
        end
    end

`ifdef COBRA_BR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken_cnt <= 16'h0;
        end else if (done_fire && !halt && take_target && (br_taken_cnt != 16'hFFFF)) begin
            br_taken_cnt <= br_taken_cnt + 16'h1;
        end
    end
`else
    logic unused_done_fire;
    assign unused_done_fire = done_fire;
`endif

endmodule
